// File: rtl/glb_pkg.sv
// rtl/glb_pkg.sv - shared constants for the GLB read ports.
// Build macro GLBRD_SKID_EN selects a 2-deep output buffer (default 1-deep).
package glb_pkg;

   localparam int GLB_SRAM_WIDTH = 256;
   localparam int GLB_IDX_WIDTH  = 10;
   localparam int GLB_RD_LATENCY = 1;

`ifdef GLBRD_SKID_EN
   localparam int GLB_RD_DEPTH = 2;
`else
   localparam int GLB_RD_DEPTH = 1;
`endif

   localparam int GLB_RD_OCC_W = $clog2(GLB_RD_DEPTH + 1);

endpackage

// File: rtl/glb_rd_fifo.sv
// rtl/glb_rd_fifo.sv - shift-style output buffer for the GLB read port.
// The head is always slot 0, so the read data leaves straight from a register.
import glb_pkg::*;

module glb_rd_fifo #(
   parameter int DEPTH      = GLB_RD_DEPTH,
   parameter int SRAM_WIDTH = GLB_SRAM_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic [SRAM_WIDTH-1:0]        push_data_i,
   input  logic                         pop_i,
   output logic [SRAM_WIDTH-1:0]        head_o,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [SRAM_WIDTH-1:0] mem_q [DEPTH];
   logic [OCC_W-1:0]      occ_q;
   logic [OCC_W-1:0]      wr_idx;

   // A simultaneous pop shifts everything down one slot before the write lands.
   assign wr_idx = occ_q - OCC_W'(pop_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
         for (int i = 0; i < DEPTH; i++) begin
            if (pop_i && (i < DEPTH - 1)) mem_q[i] <= mem_q[(i + 1) % DEPTH];
            if (push_i && (wr_idx == OCC_W'(i))) mem_q[i] <= push_data_i;
         end
      end
   end

   assign head_o = mem_q[0];
   assign occ_o  = occ_q;

endmodule

// File: rtl/glb_crd_rdport.sv
// rtl/glb_crd_rdport.sv - credit-gated SRAM read port with a registered output buffer.
// Build macro GLBRD_SKID_EN deepens the buffer to 2 for one word per cycle.
import glb_pkg::*;

module glb_crd_rdport #(
   parameter int SRAM_WIDTH = GLB_SRAM_WIDTH,
   parameter int IDX_WIDTH  = GLB_IDX_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  CCUGLB_Rst,
   input  logic [IDX_WIDTH-1:0]  CTRGLB_CrdAddr,
   input  logic                  CTRGLB_CrdAddrVld,
   output logic                  GLBCTR_CrdAddrRdy,
   output logic [SRAM_WIDTH-1:0] GLBCTR_Crd,
   output logic                  GLBCTR_CrdVld,
   input  logic                  CTRGLB_CrdRdy,
   output logic                  GLBSRAM_RdEn,
   output logic [IDX_WIDTH-1:0]  GLBSRAM_RdAddr,
   input  logic [SRAM_WIDTH-1:0] SRAMGLB_RdDat,
   input  logic                  SRAMGLB_Gnt,
   output logic [CNT_WIDTH-1:0]  GLBCCU_RdCnt,
   output logic                  GLBCCU_Idle
);

   localparam int DEPTH = GLB_RD_DEPTH;
   localparam int OCC_W = GLB_RD_OCC_W;
   localparam int LAT   = GLB_RD_LATENCY;

   logic [1:0]            rst_sync_q;
   logic [LAT-1:0]        inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [OCC_W-1:0]      occ;
   logic [SRAM_WIDTH-1:0] head;
   logic [OCC_W:0]        credit_used, credit_limit;
   logic                  rst_hold, crd_vld, pop, push, accept;

   // Reset asserts immediately but keeps accepts blocked until release is clk-aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_sync_q <= 2'b11;
      else     rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_hold = rst_sync_q[1];

   assign crd_vld = (occ != '0);
   assign pop     = crd_vld & CTRGLB_CrdRdy;
   assign push    = inflight_q[LAT-1] & ~CCUGLB_Rst;

   // occ + inflight - pop < DEPTH, rearranged so nothing underflows.
   always_comb begin
      credit_used  = {1'b0, occ} + (OCC_W + 1)'($countones(inflight_q));
      credit_limit = (OCC_W + 1)'(DEPTH) + {{OCC_W{1'b0}}, pop};
   end

   assign GLBCTR_CrdAddrRdy = SRAMGLB_Gnt & ~CCUGLB_Rst & ~rst_hold & (credit_used < credit_limit);
   assign accept            = CTRGLB_CrdAddrVld & GLBCTR_CrdAddrRdy;
   assign GLBSRAM_RdEn      = accept;
   assign GLBSRAM_RdAddr    = accept ? CTRGLB_CrdAddr : '0;

   always_comb begin
      inflight_d = CCUGLB_Rst ? '0 : LAT'({inflight_q, accept});
      cnt_d      = CCUGLB_Rst ? '0 : cnt_q + CNT_WIDTH'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
      end
   end

   glb_rd_fifo #(
      .DEPTH      (DEPTH),
      .SRAM_WIDTH (SRAM_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (CCUGLB_Rst),
      .push_i      (push),
      .push_data_i (SRAMGLB_RdDat),
      .pop_i       (pop),
      .head_o      (head),
      .occ_o       (occ)
   );

   assign GLBCTR_Crd    = head;
   assign GLBCTR_CrdVld = crd_vld;
   assign GLBCCU_RdCnt  = cnt_q;
   assign GLBCCU_Idle   = (occ == '0) & ~(|inflight_q);

endmodule
